// File: rtl/fast_n_corner_core.sv
// fast_n_corner_core: streaming FAST-N corner classifier and scorer.
// Three registered stages (classify -> arc detect -> score/output) share one
// global advance enable, so a stalled output freezes the whole pipe in place.
module fast_n_corner_core #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned ARC_LEN = 9,
  parameter int unsigned SCORE_W = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [ADDR_W-1:0]   inAddr,
  input  logic [PIX_W-1:0]    refPixel,
  input  logic [16*PIX_W-1:0] adjPixel,
  input  logic [PIX_W-1:0]    thres,
  input  logic [1:0]          modeSel,
  output logic                outValid,
  input  logic                outReady,
  output logic [ADDR_W-1:0]   outAddr,
  output logic [PIX_W-1:0]    outPixel,
  output logic                isCorner,
  output logic [SCORE_W-1:0]  outScore,
  output logic [ADDR_W-1:0]   cornerCount
);

  typedef enum logic [1:0] {
    MODE_BOTH   = 2'b00,
    MODE_BRIGHT = 2'b01,
    MODE_DARK   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  // Classification needs one guard bit so ref+thres cannot wrap.
  localparam int unsigned EXT_W = PIX_W + 1;
  // Sixteen terms of at most 2**PIX_W-1 each fit in PIX_W+4 bits.
  localparam int unsigned ACC_W = PIX_W + 4;
  localparam int unsigned SAT_W = (ACC_W > SCORE_W) ? ACC_W : SCORE_W;
  localparam logic [SAT_W-1:0] SCORE_MAX = SAT_W'({SCORE_W{1'b1}});

  // True when the circular 16-bit mask holds a run of at least ARC_LEN ones.
  function automatic logic has_arc(input logic [15:0] mask);
    logic found;
    logic run;
    found = 1'b0;
    for (int s = 0; s < 16; s++) begin
      run = 1'b1;
      for (int k = 0; k < int'(ARC_LEN); k++) begin
        run = run & mask[4'((s + k) % 16)];
      end
      found = found | run;
    end
    return found;
  endfunction

  logic advance;

  // Stage 1 registers
  logic                s1_valid_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic [PIX_W-1:0]    s1_ref_q;
  logic [PIX_W-1:0]    s1_thres_q;
  mode_e               s1_mode_q;
  logic [16*PIX_W-1:0] s1_adj_q;
  logic [15:0]         s1_bright_q, s1_dark_q;
  logic [15:0]         s1_bright_d, s1_dark_d;

  // Stage 2 registers
  logic                s2_valid_q;
  logic [ADDR_W-1:0]   s2_addr_q;
  logic [PIX_W-1:0]    s2_ref_q;
  logic [PIX_W-1:0]    s2_thres_q;
  mode_e               s2_mode_q;
  logic [16*PIX_W-1:0] s2_adj_q;
  logic [15:0]         s2_bright_q, s2_dark_q;
  logic                s2_bright_arc_q, s2_dark_arc_q;
  logic                s2_bright_arc_d, s2_dark_arc_d;

  // Stage 3 (output) registers
  logic                out_valid_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [PIX_W-1:0]    out_pixel_q;
  logic                out_corner_q;
  logic [SCORE_W-1:0]  out_score_q;
  logic                out_corner_d;
  logic [SCORE_W-1:0]  out_score_d;

  logic [ADDR_W-1:0]   count_q, count_d;

  // A held output blocks everything behind it; otherwise the pipe moves.
  assign advance = !out_valid_q || outReady;
  assign inReady = advance;

  // Per-pixel bright/dark classification at PIX_W+1 bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    s1_bright_d = '0;
    s1_dark_d   = '0;
    for (int i = 0; i < 16; i++) begin
      s1_bright_d[i] = {1'b0, adjPixel[i*PIX_W +: PIX_W]}
                       > ({1'b0, refPixel} + {1'b0, thres});
      s1_dark_d[i]   = ({1'b0, adjPixel[i*PIX_W +: PIX_W]} + {1'b0, thres})
                       < {1'b0, refPixel};
    end
  end

  // Stage 1 register: capture the beat and its classification masks.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: datapath registers are reset too, so every output reads 0 straight out of reset.
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_ref_q    <= '0;
      s1_thres_q  <= '0;
      s1_mode_q   <= MODE_BOTH;
      s1_adj_q    <= '0;
      s1_bright_q <= '0;
      s1_dark_q   <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge values of the others.
      s1_valid_q  <= inValid;
      s1_addr_q   <= inAddr;
      s1_ref_q    <= refPixel;
      s1_thres_q  <= thres;
      s1_mode_q   <= mode_e'(modeSel);
      s1_adj_q    <= adjPixel;
      s1_bright_q <= s1_bright_d;
      s1_dark_q   <= s1_dark_d;
    end
  end

  // Circular arc search over the classification masks.
  always_comb begin
    s2_bright_arc_d = has_arc(s1_bright_q);
    s2_dark_arc_d   = has_arc(s1_dark_q);
  end

  // Stage 2 register: carry the beat forward with its arc flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_q      <= 1'b0;
      s2_addr_q       <= '0;
      s2_ref_q        <= '0;
      s2_thres_q      <= '0;
      s2_mode_q       <= MODE_BOTH;
      s2_adj_q        <= '0;
      s2_bright_q     <= '0;
      s2_dark_q       <= '0;
      s2_bright_arc_q <= 1'b0;
      s2_dark_arc_q   <= 1'b0;
    end else if (advance) begin
      s2_valid_q      <= s1_valid_q;
      s2_addr_q       <= s1_addr_q;
      s2_ref_q        <= s1_ref_q;
      s2_thres_q      <= s1_thres_q;
      s2_mode_q       <= s1_mode_q;
      s2_adj_q        <= s1_adj_q;
      s2_bright_q     <= s1_bright_q;
      s2_dark_q       <= s1_dark_q;
      s2_bright_arc_q <= s2_bright_arc_d;
      s2_dark_arc_q   <= s2_dark_arc_d;
    end
  end

  // Mode gating and saturating score accumulation over the winning polarity.
  logic [ACC_W-1:0] acc;
  logic [EXT_W-1:0] term;
  logic [SAT_W-1:0] acc_ext;
  logic [PIX_W-1:0] adj_px;
  always_comb begin
    acc     = '0;
    term    = '0;
    adj_px  = '0;
    for (int i = 0; i < 16; i++) begin
      adj_px = s2_adj_q[i*PIX_W +: PIX_W];
      if (s2_bright_arc_q && s2_bright_q[i]) begin
        term = {1'b0, adj_px} - {1'b0, s2_ref_q} - {1'b0, s2_thres_q};
        acc  = acc + ACC_W'(term);
      end else if (s2_dark_arc_q && s2_dark_q[i]) begin
        term = {1'b0, s2_ref_q} - {1'b0, s2_thres_q} - {1'b0, adj_px};
        acc  = acc + ACC_W'(term);
      end
    end
    acc_ext = SAT_W'(acc);

    out_corner_d = (s2_bright_arc_q && s2_mode_q != MODE_DARK   && s2_mode_q != MODE_OFF)
                || (s2_dark_arc_q   && s2_mode_q != MODE_BRIGHT && s2_mode_q != MODE_OFF);
    out_score_d  = '0;
    if (out_corner_d) begin
      out_score_d = (acc_ext > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : acc_ext[SCORE_W-1:0];
    end
  end

  // Stage 3 register: result beat, held stable while downstream stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_pixel_q  <= '0;
      out_corner_q <= 1'b0;
      out_score_q  <= '0;
    end else if (advance) begin
      out_valid_q  <= s2_valid_q;
      out_addr_q   <= s2_addr_q;
      out_pixel_q  <= s2_ref_q;
      out_corner_q <= out_corner_d;
      out_score_q  <= out_score_d;
    end
  end

  // Corner counter steps on each accepted corner result and sticks at all ones.
  always_comb begin
    count_d = count_q;
    if (out_valid_q && outReady && out_corner_q && (count_q != {ADDR_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Corner counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign outValid    = out_valid_q;
  assign outAddr     = out_addr_q;
  assign outPixel    = out_pixel_q;
  assign isCorner    = out_corner_q;
  assign outScore    = out_score_q;
  assign cornerCount = count_q;

endmodule

// File: tb/tb_fast_n_corner_core.sv
// Directed bench for fast_n_corner_core: default ARC_LEN=9 build plus an ARC_LEN=12 build
// sharing the same stimulus.
module tb_fast_n_corner_core;

  logic         clock = 1'b0;
  logic         reset;
  logic         inValid, inReady, outReady, outValid, isCorner;
  logic [14:0]  inAddr, outAddr, cornerCount;
  logic [7:0]   refPixel, thres, outPixel;
  logic [127:0] adjPixel;
  logic [1:0]   modeSel;
  logic [11:0]  outScore;

  logic         inReady12, outValid12, isCorner12;
  logic [14:0]  outAddr12, cornerCount12;
  logic [7:0]   outPixel12;
  logic [11:0]  outScore12;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cc   = 0;
  int exp_cc12 = 0;

  always #5 clock = ~clock;

  fast_n_corner_core dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inAddr(inAddr), .refPixel(refPixel), .adjPixel(adjPixel), .thres(thres),
    .modeSel(modeSel), .outValid(outValid), .outReady(outReady), .outAddr(outAddr),
    .outPixel(outPixel), .isCorner(isCorner), .outScore(outScore), .cornerCount(cornerCount)
  );

  fast_n_corner_core #(.ARC_LEN(12)) dut12 (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady12),
    .inAddr(inAddr), .refPixel(refPixel), .adjPixel(adjPixel), .thres(thres),
    .modeSel(modeSel), .outValid(outValid12), .outReady(outReady), .outAddr(outAddr12),
    .outPixel(outPixel12), .isCorner(isCorner12), .outScore(outScore12), .cornerCount(cornerCount12)
  );

  function automatic logic [127:0] make_ring(input logic [15:0] mask, input logic [7:0] hi,
                                             input logic [7:0] lo);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = mask[i] ? hi : lo;
    return r;
  endfunction

  // Drive one beat at a negedge, then stop at the negedge following the third
  // register stage. early is set if outValid showed up before that.
  task automatic run_beat(input logic [14:0] a, input logic [7:0] r, input logic [7:0] t,
                          input logic [127:0] ring, input logic [1:0] m, output logic early);
    inAddr = a; refPixel = r; thres = t; adjPixel = ring; modeSel = m;
    inValid = 1'b1; outReady = 1'b1;
    @(posedge clock); #1 inValid = 1'b0;
    @(negedge clock); early = outValid;
    @(negedge clock); early = early | outValid;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; inValid = 1'b0; outReady = 1'b1; inAddr = '0; refPixel = '0;
    thres = '0; adjPixel = '0; modeSel = 2'b00;
    repeat (2) @(negedge clock);
    n_checks++; if (outValid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", outValid); else n_pass++;
    n_checks++; if (cornerCount !== 15'd0) $display("FAIL rst_count: got %0d want 0", cornerCount); else n_pass++;
    n_checks++;
    if (outScore !== 12'd0 || isCorner !== 1'b0 || outAddr !== 15'd0 || outPixel !== 8'd0)
      $display("FAIL rst_outputs: got score=%0d corner=%0b addr=%0d pix=%0d want all 0",
               outScore, isCorner, outAddr, outPixel);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (inReady !== 1'b1 || inReady12 !== 1'b1)
      $display("FAIL rst_inready: got %0b/%0b want 1/1", inReady, inReady12);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_bright_arc;
    logic early;
    run_beat(15'd1234, 8'd100, 8'd10, make_ring(16'hC07F, 8'd120, 8'd100), 2'b00, early);
    exp_cc++;
    n_checks++; if (early !== 1'b0) $display("FAIL t1_latency: outValid early got %0b want 0", early); else n_pass++;
    n_checks++; if (outValid !== 1'b1) $display("FAIL t1_valid: got %0b want 1", outValid); else n_pass++;
    n_checks++; if (isCorner !== 1'b1) $display("FAIL t1_corner: got %0b want 1", isCorner); else n_pass++;
    n_checks++; if (outScore !== 12'd90) $display("FAIL t1_score: got %0d want 90", outScore); else n_pass++;
    n_checks++;
    if (outAddr !== 15'd1234 || outPixel !== 8'd100)
      $display("FAIL t1_addr_pix: got %0d/%0d want 1234/100", outAddr, outPixel);
    else n_pass++;
    n_checks++; if (isCorner12 !== 1'b0) $display("FAIL t1_arc12: got %0b want 0", isCorner12); else n_pass++;
    @(negedge clock);
    n_checks++; if (cornerCount !== 15'(exp_cc)) $display("FAIL t1_count: got %0d want %0d", cornerCount, exp_cc); else n_pass++;
    n_checks++; if (outValid !== 1'b0) $display("FAIL t1_bubble: got %0b want 0", outValid); else n_pass++;
  endtask

  task automatic test_near_miss;
    logic early;
    run_beat(15'd10, 8'd100, 8'd10, make_ring(16'hC03F, 8'd120, 8'd100), 2'b00, early);
    n_checks++;
    if (outValid !== 1'b1 || isCorner !== 1'b0 || outScore !== 12'd0)
      $display("FAIL t2_arc8: got v=%0b c=%0b s=%0d want 1/0/0", outValid, isCorner, outScore);
    else n_pass++;
    run_beat(15'd11, 8'd100, 8'd10, make_ring(16'hFFFF, 8'd110, 8'd110), 2'b00, early);
    n_checks++;
    if (outValid !== 1'b1 || isCorner !== 1'b0 || outScore !== 12'd0)
      $display("FAIL t2_equal: got v=%0b c=%0b s=%0d want 1/0/0", outValid, isCorner, outScore);
    else n_pass++;
  endtask

  task automatic test_modes;
    logic early;
    logic [127:0] dark_ring;
    logic [127:0] bright_ring;
    dark_ring   = make_ring(16'hFFFF, 8'd0, 8'd0);
    bright_ring = make_ring(16'hC07F, 8'd120, 8'd100);
    run_beat(15'd20, 8'd200, 8'd20, dark_ring, 2'b01, early);
    n_checks++;
    if (isCorner !== 1'b0 || outScore !== 12'd0)
      $display("FAIL t3_dark_mode01: got c=%0b s=%0d want 0/0", isCorner, outScore);
    else n_pass++;
    run_beat(15'd21, 8'd200, 8'd20, dark_ring, 2'b10, early);
    exp_cc++; exp_cc12++;
    n_checks++;
    if (isCorner !== 1'b1 || outScore !== 12'd2880)
      $display("FAIL t3_dark_mode10: got c=%0b s=%0d want 1/2880", isCorner, outScore);
    else n_pass++;
    run_beat(15'd22, 8'd200, 8'd20, dark_ring, 2'b00, early);
    exp_cc++; exp_cc12++;
    n_checks++;
    if (isCorner !== 1'b1 || outScore !== 12'd2880)
      $display("FAIL t3_dark_mode00: got c=%0b s=%0d want 1/2880", isCorner, outScore);
    else n_pass++;
    run_beat(15'd23, 8'd200, 8'd20, dark_ring, 2'b11, early);
    n_checks++;
    if (isCorner !== 1'b0 || outScore !== 12'd0)
      $display("FAIL t3_dark_mode11: got c=%0b s=%0d want 0/0", isCorner, outScore);
    else n_pass++;
    run_beat(15'd24, 8'd100, 8'd10, bright_ring, 2'b10, early);
    n_checks++;
    if (isCorner !== 1'b0 || outScore !== 12'd0)
      $display("FAIL t3_bright_mode10: got c=%0b s=%0d want 0/0", isCorner, outScore);
    else n_pass++;
    run_beat(15'd25, 8'd100, 8'd10, bright_ring, 2'b01, early);
    exp_cc++;
    n_checks++;
    if (isCorner !== 1'b1 || outScore !== 12'd90)
      $display("FAIL t3_bright_mode01: got c=%0b s=%0d want 1/90", isCorner, outScore);
    else n_pass++;
  endtask

  task automatic test_arc12;
    logic early;
    run_beat(15'd30, 8'd100, 8'd10, make_ring(16'h07FF, 8'd120, 8'd100), 2'b00, early);
    exp_cc++;
    n_checks++;
    if (outValid12 !== 1'b1 || isCorner12 !== 1'b0 || outScore12 !== 12'd0)
      $display("FAIL t4_arc11_len12: got v=%0b c=%0b s=%0d want 1/0/0", outValid12, isCorner12, outScore12);
    else n_pass++;
    n_checks++;
    if (isCorner !== 1'b1 || outScore !== 12'd110)
      $display("FAIL t4_arc11_len9: got c=%0b s=%0d want 1/110", isCorner, outScore);
    else n_pass++;
    run_beat(15'd31, 8'd100, 8'd10, make_ring(16'hF0FF, 8'd120, 8'd100), 2'b00, early);
    exp_cc++; exp_cc12++;
    n_checks++;
    if (isCorner12 !== 1'b1 || outScore12 !== 12'd120 || outAddr12 !== 15'd31 || outPixel12 !== 8'd100)
      $display("FAIL t4_arc12_len12: got c=%0b s=%0d a=%0d p=%0d want 1/120/31/100",
               isCorner12, outScore12, outAddr12, outPixel12);
    else n_pass++;
    n_checks++;
    if (isCorner !== 1'b1 || outScore !== 12'd120)
      $display("FAIL t4_arc12_len9: got c=%0b s=%0d want 1/120", isCorner, outScore);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (cornerCount12 !== 15'(exp_cc12))
      $display("FAIL t4_count12: got %0d want %0d", cornerCount12, exp_cc12);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int sent;
    int got;
    logic stalled_prev;
    logic [14:0] pa;
    logic [11:0] ps;
    logic pc;
    logic [11:0] want_s;
    logic want_c;
    sent = 0; got = 0; stalled_prev = 1'b0; pa = '0; ps = '0; pc = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      @(negedge clock);
      outReady = !(cyc >= 4 && cyc < 9);
      if (sent < 6) begin
        inAddr = 15'(200 + sent); refPixel = 8'd100; thres = 8'd10; modeSel = 2'b00;
        adjPixel = make_ring((sent == 3) ? 16'hC03F : 16'hC07F, 8'(111 + sent), 8'd100);
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        n_checks++;
        if (outValid !== 1'b1 || outAddr !== pa || outScore !== ps || isCorner !== pc)
          $display("FAIL t5_hold: got v=%0b a=%0d s=%0d c=%0b want 1/%0d/%0d/%0b",
                   outValid, outAddr, outScore, isCorner, pa, ps, pc);
        else n_pass++;
      end
      if (outValid && !outReady) begin
        n_checks++; if (inReady !== 1'b0) $display("FAIL t5_inready: got %0b want 0", inReady); else n_pass++;
      end
      stalled_prev = outValid && !outReady;
      pa = outAddr; ps = outScore; pc = isCorner;
      if (outValid && outReady) begin
        want_c = (got != 3);
        want_s = want_c ? 12'(9 * (1 + got)) : 12'd0;
        n_checks++;
        if (outAddr !== 15'(200 + got) || isCorner !== want_c || outScore !== want_s || outPixel !== 8'd100)
          $display("FAIL t5_beat%0d: got a=%0d c=%0b s=%0d p=%0d want %0d/%0b/%0d/100",
                   got, outAddr, isCorner, outScore, outPixel, 200 + got, want_c, want_s);
        else n_pass++;
        if (want_c) exp_cc++;
        got++;
      end
      if (inValid && inReady) sent++;
    end
    inValid = 1'b0; outReady = 1'b1;
    n_checks++; if (got != 6) $display("FAIL t5_timeout: got %0d beats want 6", got); else n_pass++;
    @(negedge clock);
    n_checks++; if (cornerCount !== 15'(exp_cc)) $display("FAIL t5_count: got %0d want %0d", cornerCount, exp_cc); else n_pass++;
  endtask

  task automatic test_reset_midstream;
    logic early;
    outReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inAddr = 15'(300 + k); refPixel = 8'd100; thres = 8'd10; modeSel = 2'b00;
      adjPixel = make_ring(16'hC07F, 8'd120, 8'd100);
      inValid = 1'b1;
      @(posedge clock); #1;
    end
    inValid = 1'b0;
    n_checks++; if (outValid !== 1'b1) $display("FAIL t6_pre_valid: got %0b want 1", outValid); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (outValid !== 1'b0) $display("FAIL t6_async_valid: got %0b want 0", outValid); else n_pass++;
    n_checks++; if (cornerCount !== 15'd0) $display("FAIL t6_async_count: got %0d want 0", cornerCount); else n_pass++;
    @(negedge clock); #2 reset = 1'b0;
    @(negedge clock);
    n_checks++; if (inReady !== 1'b1) $display("FAIL t6_inready: got %0b want 1", inReady); else n_pass++;
    run_beat(15'd400, 8'd100, 8'd10, make_ring(16'hC07F, 8'd120, 8'd100), 2'b00, early);
    n_checks++; if (early !== 1'b0) $display("FAIL t6_no_replay: stale outValid got %0b want 0", early); else n_pass++;
    n_checks++;
    if (outValid !== 1'b1 || outAddr !== 15'd400 || isCorner !== 1'b1 || outScore !== 12'd90)
      $display("FAIL t6_next_beat: got v=%0b a=%0d c=%0b s=%0d want 1/400/1/90",
               outValid, outAddr, isCorner, outScore);
    else n_pass++;
    @(negedge clock);
    n_checks++; if (cornerCount !== 15'd1) $display("FAIL t6_count: got %0d want 1", cornerCount); else n_pass++;
    n_checks++; if (outValid !== 1'b0) $display("FAIL t6_drain: got %0b want 0", outValid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bright_arc();
    test_near_miss();
    test_modes();
    test_arc12();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
